// File: rtl/uart_pkg.sv
// Shared UART constants: data width and default receive FIFO geometry.
package uart_pkg;
   localparam int UART_DW             = 8;
   localparam int FIFO_DEPTH_LOG2_DEF = 4;
   localparam int FIFO_THRESH_DEF     = 8;
endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x UART_DW array, synchronous write and asynchronous read (distributed RAM).
// Write lands on the clock edge; read data follows raddr combinationally; no flow control.
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int AW = FIFO_DEPTH_LOG2_DEF
) (
   input  logic               rx_clk,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [UART_DW-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [UART_DW-1:0] rdata
);

   logic [UART_DW-1:0] mem [0:(1<<AW)-1];

   // No reset on the array so it maps onto LUT RAM.
   always_ff @(posedge rx_clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive byte FIFO: one-cycle write-to-visible latency, head byte on rd_data combinationally.
// Bytes arriving while full are dropped (sticky overrun) unless a pop happens in the same cycle.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2_DEF,
   parameter int THRESH     = FIFO_THRESH_DEF
) (
   input  logic                  rx_clk,
   input  logic                  reset_n,
   input  logic [UART_DW-1:0]    rx_data,
   input  logic                  rx_done,
   input  logic                  rd_en,
   output logic [UART_DW-1:0]    rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overrun,
   input  logic                  ovr_clr,
   output logic                  irq
);

   localparam int                LVL_W    = DEPTH_LOG2 + 1;
   localparam int                DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  LVL_THR  = LVL_W'(THRESH);

   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [LVL_W-1:0]      level_q;
   logic                  overrun_q;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  drop;

   assign empty = (level_q == '0);
   assign full  = (level_q == LVL_FULL);
   assign irq   = (level_q >= LVL_THR);
   assign level = level_q;
   assign overrun = overrun_q;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
   assign wr_acc = rx_done && (!full || rd_en);
   assign rd_acc = rd_en && !empty;
   assign drop   = rx_done && full && !rd_en;

   always_ff @(posedge rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_acc, rd_acc})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
         if (drop)         overrun_q <= 1'b1;
         else if (ovr_clr) overrun_q <= 1'b0;
      end
   end

   uart_fifo_ram #(
      .AW (DEPTH_LOG2)
   ) u_ram (
      .rx_clk (rx_clk),
      .we     (wr_acc),
      .waddr  (wr_ptr),
      .wdata  (rx_data),
      .raddr  (rd_ptr),
      .rdata  (rd_data)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Queue-model bench for uart_rx_fifo: directed plan items plus randomized traffic.
module tb_uart_rx_fifo;

   localparam int DL     = 4;
   localparam int DEPTH  = 16;
   localparam int THRESH = 8;

   logic         rx_clk  = 1'b0;
   logic         reset_n = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_done = 1'b0;
   logic         rd_en   = 1'b0;
   logic         ovr_clr = 1'b0;
   logic [7:0]   rd_data;
   logic         empty, full, overrun, irq;
   logic [DL:0]  level;

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   byte unsigned mq[$];
   bit           m_ovr = 1'b0;

   uart_rx_fifo #(.DEPTH_LOG2(DL), .THRESH(THRESH)) dut (
      .rx_clk  (rx_clk),
      .reset_n (reset_n),
      .rx_data (rx_data),
      .rx_done (rx_done),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full),
      .level   (level),
      .overrun (overrun),
      .ovr_clr (ovr_clr),
      .irq     (irq)
   );

   always #5 rx_clk = ~rx_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a byte queue bounded at DEPTH, pop-before-push when both happen.
   always @(posedge rx_clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_ovr = 1'b0;
      end else begin
         bit can_rd, can_wr, dropped;
         can_rd  = rd_en && (mq.size() > 0);
         can_wr  = rx_done && ((mq.size() < DEPTH) || rd_en);
         dropped = rx_done && (mq.size() == DEPTH) && !rd_en;
         if (can_rd) void'(mq.pop_front());
         if (can_wr) mq.push_back(rx_data);
         if (dropped)      m_ovr = 1'b1;
         else if (ovr_clr) m_ovr = 1'b0;
      end
   end

   always @(negedge rx_clk) begin
      if (cmp_en) begin
         chk("cmp_level",   32'(level),   32'(mq.size()));
         chk("cmp_empty",   32'(empty),   32'(mq.size() == 0));
         chk("cmp_full",    32'(full),    32'(mq.size() == DEPTH));
         chk("cmp_irq",     32'(irq),     32'(mq.size() >= THRESH));
         chk("cmp_overrun", 32'(overrun), 32'(m_ovr));
         if (mq.size() > 0) chk("cmp_rd_data", 32'(rd_data), 32'(mq[0]));
      end
   end

   task automatic cyc(input logic d, input logic [7:0] dat, input logic r, input logic c);
      rx_done = d;
      rx_data = dat;
      rd_en   = r;
      ovr_clr = c;
      @(posedge rx_clk);
      #1;
      rx_done = 1'b0;
      rd_en   = 1'b0;
      ovr_clr = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_b;
      int pw, pr;

      repeat (3) @(posedge rx_clk);
      #1 reset_n = 1'b1;
      cmp_en = 1'b1;

      // Reset / idle
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_full", 32'(full), 32'd0);
      chk("idle_level", 32'(level), 32'd0);
      chk("idle_overrun", 32'(overrun), 32'd0);
      chk("idle_irq", 32'(irq), 32'd0);

      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("a5_empty", 32'(empty), 32'd0);
      chk("a5_level", 32'(level), 32'd1);
      chk("a5_data", 32'(rd_data), 32'hA5);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("a5_pop_empty", 32'(empty), 32'd1);
      chk("a5_pop_level", 32'(level), 32'd0);

      // Fill ordering
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 6)  chk("fill_irq_low", 32'(irq), 32'd0);
         if (i == 7)  chk("fill_irq_high", 32'(irq), 32'd1);
         if (i == 14) chk("fill_not_full", 32'(full), 32'd0);
      end
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_level", 32'(level), 32'd16);

      // Overrun: drop, set-beats-clear, clear alone
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("ovr_level", 32'(level), 32'd16);
      chk("ovr_set", 32'(overrun), 32'd1);
      cyc(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("ovr_set_prio", 32'(overrun), 32'd1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      chk("ovr_clr", 32'(overrun), 32'd0);

      // Full + write + read: both accepted
      chk("full_head", 32'(rd_data), 32'h00);
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      chk("full_rw_level", 32'(level), 32'd16);
      chk("full_rw_ovr", 32'(overrun), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         exp_b = (i < DEPTH - 1) ? 8'(i + 1) : 8'h55;
         chk("drain_order", 32'(rd_data), 32'(exp_b));
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Empty + write + read: read ignored
      cyc(1'b1, 8'h77, 1'b1, 1'b0);
      chk("empty_rw_level", 32'(level), 32'd1);
      chk("empty_rw_data", 32'(rd_data), 32'h77);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("empty_pop_noerr", 32'(overrun), 32'd0);

      // Wrap-around at constant level 3
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
         if (i % 10 == 9) chk("wrap_level", 32'(level), 32'd3);
      end
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // Async reset mid-operation with level=5, overrun=1
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      cyc(1'b1, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("pre_rst_level", 32'(level), 32'd5);
      chk("pre_rst_ovr", 32'(overrun), 32'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      #1 reset_n = 1'b1;
      cyc(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("post_rst_data", 32'(rd_data), 32'h3C);
      chk("post_rst_level", 32'(level), 32'd1);

      // Randomized traffic in phases of differing write/read pressure
      for (int ph = 0; ph < 15; ph++) begin
         pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 20;
         pr = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 50 : 80;
         for (int k = 0; k < 200; k++)
            cyc(($urandom_range(0, 99) < pw), 8'($urandom),
                ($urandom_range(0, 99) < pr), ($urandom_range(0, 31) == 0));
      end

      @(negedge rx_clk);
      #1;
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receive core. Captures each completed byte (rx_data qualified by the one-cycle rx_done pulse) into a synchronous circular FIFO clocked by rx_clk. Presents the head byte first-word-fall-through to the Avalon slave register logic. Provides empty/full/level status, a sticky overrun flag and a level-threshold interrupt.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries; legal range 1..8.
THRESH, 8, irq asserts when level >= THRESH; legal range 1..DEPTH.

Ports:
rx_clk  input  1  clock.
reset_n  input  1  reset.
rx_data  input  8  received byte from the receive core; sampled only when rx_done=1.
rx_done  input  1  one-cycle write strobe from the receive core.
rd_en  input  1  pop the head entry; ignored when empty.
rd_data  output  8  head entry (FWFT); valid only when empty=0.
empty  output  1  level == 0.
full  output  1  level == DEPTH.
level  output  DEPTH_LOG2+1  number of stored bytes, 0..DEPTH.
overrun  output  1  sticky: a byte was dropped because the FIFO was full.
ovr_clr  input  1  clears overrun.
irq  output  1  level >= THRESH.

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock rx_clk. All state updates on posedge rx_clk.
- Reset values: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, overrun=0, irq=0. rd_data = mem[0], contents don't-care. Memory array is not reset.
- Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0. level is a registered counter, not derived from the pointers.
- Write accept: rx_done && (!full || rd_en). On accept: mem[wr_ptr] <= rx_data; wr_ptr++.
- Read accept: rd_en && !empty. On accept: rd_ptr++.
- level update:
  - +1 on write only.
  - -1 on read only.
  - unchanged on both or neither.
- Write latency: a byte written at edge N is visible on rd_data with empty=0 after edge N (next cycle).
- rd_data = mem[rd_ptr], combinational read of the array; it changes the cycle after a read accept.
- empty, full and irq are decoded combinationally from the registered level.
- Full + rx_done + rd_en: both accepted, level stays DEPTH, no overrun.
- Full + rx_done without rd_en: byte dropped, pointers and level unchanged, overrun <= 1.
- Empty + rx_done + rd_en: write accepted, read ignored, level becomes 1.
- rd_en while empty with no write: no effect, no error flag.
- overrun:
  - Set has priority over ovr_clr in the same cycle, so the flag stays 1.
  - ovr_clr alone clears it next cycle.
  - Reads do not clear it.
- No frame/stop-bit checking; every rx_done is treated as a valid byte.
- Reset asserted mid-operation: all pointers, level and flags return to reset values immediately (async). Stored data is lost.

Decomposition:
- Shared package (uart_pkg): UART data width constant (8), default FIFO depth/threshold constants.
- One sub-module, uart_fifo_ram:
  - DEPTH x 8 array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - Keeps the array inferable as distributed RAM.
- Pointer, level and flag logic stay in uart_rx_fifo.

Test Plan:
- Reset then idle: empty=1, full=0, level=0, overrun=0, irq=0. Single rx_done with rx_data=8'hA5 -> next cycle empty=0, level=1, rd_data=8'hA5. rd_en one cycle -> empty=1, level=0.
- Fill ordering with defaults (DEPTH=16): write 16 bytes 8'h00..8'h0F. irq asserts the cycle after the 8th write (level=8); full=1 at level=16. Pop all 16 -> rd_data sequence 00..0F in order, empty=1 at end.
- Overrun: at full, write 8'hFF without rd_en -> level stays 16, overrun=1; next pop returns 8'h00 (dropped byte absent). Assert ovr_clr and a new dropped write together -> overrun stays 1. ovr_clr alone -> overrun=0.
- Simultaneous events:
  - At full, rx_done=1 (8'h55) with rd_en=1 -> level stays 16, overrun=0; 8'h55 emerges as the 16th subsequent pop.
  - At empty, rx_done+rd_en -> level=1, rd_data=new byte.
- Wrap-around: 40 interleaved write/read pairs with level held at 3 -> pointers wrap twice; every popped byte matches the scoreboard.
- Async reset mid-operation: with level=5 and overrun=1, pulse reset_n low between clock edges -> outputs return to reset values before the next edge; subsequent write 8'h3C reads back correctly.
